ysyx_23060171_pcu: RTL and testbench

Program-counter unit. It sits directly downstream of the next-PC source decoder (idupc) and directly upstream of the IFU.
- Owns the architectural PC register.
- Consumes the 3-bit PCSrc code plus the operands each source needs, and computes the next PC.
- Issues one fetch request per instruction to the IFU over a valid/ready handshake.
- Keeps a retired-instruction counter.

---
 rtl/ysyx_23060171_pcu.sv | 97 +++++++++
 tb/tb_ysyx_23060171_pcu.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060171_pcu.sv
// ============================================================================
// ysyx_23060171_pcu : program-counter unit, owns the PC and issues one fetch per
// retired instruction to the IFU; counts retired instructions.  Rev 1.0
// ============================================================================
`default_nettype none

module ysyx_23060171_pcu #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      pc_src,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic            out_misalign,
    output logic [31:0]     inst_cnt
);

    localparam logic [0:0] S_REQ  = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    localparam logic [2:0] c_SRC_SNPC   = 3'b000;
    localparam logic [2:0] c_SRC_DNPC   = 3'b001;
    localparam logic [2:0] c_SRC_DNPC_R = 3'b010;
    localparam logic [2:0] c_SRC_MTVEC  = 3'b011;
    localparam logic [2:0] c_SRC_MEPC   = 3'b100;

    localparam logic [XLEN-1:0] c_JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    logic [0:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [XLEN-1:0] w_next_pc;

    // All outputs decode from registered state only.
    assign out_valid    = (state_q == S_REQ);
    assign in_ready     = (state_q == S_WAIT);
    assign out_pc       = pc_q;
    assign out_misalign = |pc_q[1:0];
    assign inst_cnt     = cnt_q;

    always_comb begin
        w_next_pc = pc_q + XLEN'(4);
        case (pc_src)
            c_SRC_SNPC:   w_next_pc = pc_q + XLEN'(4);
            c_SRC_DNPC:   w_next_pc = pc_q + imm;
            c_SRC_DNPC_R: w_next_pc = (rs1 + imm) & c_JALR_MASK;
            c_SRC_MTVEC:  w_next_pc = mtvec;
            c_SRC_MEPC:   w_next_pc = mepc;
            default:      w_next_pc = pc_q + XLEN'(4);
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_REQ: begin
                if (out_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (in_valid) begin
                    pc_d    = w_next_pc;
                    cnt_d   = cnt_q + 32'd1;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060171_pcu.sv
// ============================================================================
// tb_ysyx_23060171_pcu : directed self-checking bench for the program-counter unit.
// ============================================================================
`default_nettype none

module tb_ysyx_23060171_pcu;

    localparam logic [31:0] c_RESET_PC = 32'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  pc_src;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic        out_misalign;
    logic [31:0] inst_cnt;

    int n_cmp;
    int n_bad;
    logic [31:0] exp_cnt;

    ysyx_23060171_pcu #(
        .XLEN     (32),
        .RESET_PC (c_RESET_PC)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pc_src       (pc_src),
        .imm          (imm),
        .rs1          (rs1),
        .mtvec        (mtvec),
        .mepc         (mepc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_misalign (out_misalign),
        .inst_cnt     (inst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge while the DUT is in REQ (or WAIT); completes one
    // fetch + redirect pair and checks the new request.
    task automatic retire(input string tag, input logic [2:0] src, input logic [31:0] i_imm,
                          input logic [31:0] i_rs1, input logic [31:0] i_mtv,
                          input logic [31:0] i_mep, input logic [31:0] exp_pc);
        int n;
        pc_src   = src;
        imm      = i_imm;
        rs1      = i_rs1;
        mtvec    = i_mtv;
        mepc     = i_mep;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_wait_timeout"}, 32'(n >= 20), 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        exp_cnt = exp_cnt + 32'd1;
        @(negedge clk);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_pc"}, out_pc, exp_pc);
        chk({tag, "_misalign"}, 32'(out_misalign), 32'(exp_pc[1:0] != 2'b00));
        chk({tag, "_cnt"}, inst_cnt, exp_cnt);
    endtask

    initial begin
        logic [31:0] held_pc;
        n_cmp     = 0;
        n_bad     = 0;
        exp_cnt   = 32'd0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        pc_src    = 3'b000;
        imm       = 32'd0;
        rs1       = 32'd0;
        mtvec     = 32'd0;
        mepc      = 32'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd1);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_pc", out_pc, c_RESET_PC);
        chk("rst_cnt", inst_cnt, 32'd0);
        chk("rst_mis", 32'(out_misalign), 32'd0);
        rst_n = 1'b1;

        // First fetch accepted at the first edge, in_ready the cycle after
        @(negedge clk);
        chk("first_in_ready", 32'(in_ready), 32'd1);
        chk("first_out_valid", 32'(out_valid), 32'd0);
        chk("first_cnt", inst_cnt, 32'd0);

        retire("seq1", 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h8000_0004);
        retire("seq2", 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h8000_0008);
        retire("seq3", 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h8000_000C);
        retire("seq4", 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h8000_0010);

        retire("dnpc",   3'b001, 32'hFFFF_FFF0, 32'h0, 32'h0, 32'h0, 32'h8000_0000);
        retire("dnpc_r", 3'b010, 32'h0000_0002, 32'h8000_0101, 32'h0, 32'h0, 32'h8000_0102);
        retire("mtvec",  3'b011, 32'h0, 32'h0, 32'h8000_1000, 32'h0, 32'h8000_1000);
        retire("mepc",   3'b100, 32'h0, 32'h0, 32'h0, 32'h8000_0044, 32'h8000_0044);
        retire("rsv111", 3'b111, 32'h1234, 32'h0, 32'h0, 32'h0, 32'h8000_0048);
        retire("rsv101", 3'b101, 32'h1234, 32'h0, 32'h0, 32'h0, 32'h8000_004C);

        // Backpressure, with a stray in_valid that must be ignored in REQ
        out_ready = 1'b0;
        in_valid  = 1'b1;
        pc_src    = 3'b001;
        imm       = 32'h0000_0100;
        held_pc   = 32'h8000_004C;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_pc", out_pc, held_pc);
            chk("bp_ready", 32'(in_ready), 32'd0);
            chk("bp_cnt", inst_cnt, exp_cnt);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Wrap around the top of the address space
        retire("to_top", 3'b100, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        retire("wrap",   3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_0000);

        // Async reset mid-WAIT, between edges
        @(negedge clk);
        chk("pre_rst_wait", 32'(in_ready), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd1);
        chk("arst_ready", 32'(in_ready), 32'd0);
        chk("arst_pc", out_pc, c_RESET_PC);
        chk("arst_cnt", inst_cnt, 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 32'd0;
        retire("post_rst", 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h8000_0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
